// File: rtl/rs_pkg.sv
// Shared types for the reservation station: entry layout, widths, command-bit
// positions (common with decode) and the operand wakeup helper.
package rs_pkg;

  localparam int CMD_W = 10;
  localparam int VAL_W = 65;
  localparam int TAG_W = 4;

  localparam int MEMWRITE      = 0;
  localparam int MEMTOREG      = 1;
  localparam int ALUOP_LO      = 2;
  localparam int ALUOP_HI      = 4;
  localparam int REGWRITE      = 5;
  localparam int NEEDTOFORWARD = 6;
  localparam int LEFTSHIFT     = 7;
  localparam int SAVECOND      = 8;
  localparam int READEN        = 9;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] destTag;
    logic [TAG_W-1:0] tag1;
    logic [VAL_W-1:0] val1;
    logic [TAG_W-1:0] tag2;
    logic [VAL_W-1:0] val2;
    logic [CMD_W-1:0] cmd;
  } rs_entry_t;

  // Tag 0 means "value present", so it can never be matched by a broadcast.
  function automatic rs_entry_t rs_wake(input rs_entry_t e, input logic cv,
                                        input logic [TAG_W-1:0] ct,
                                        input logic [VAL_W-1:0] cval);
    rs_entry_t w;
    w = e;
    if (cv && (e.tag1 != '0) && (e.tag1 == ct)) begin
      w.tag1 = '0;
      w.val1 = cval;
    end
    if (cv && (e.tag2 != '0) && (e.tag2 == ct)) begin
      w.tag2 = '0;
      w.val2 = cval;
    end
    return w;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Decode write port, completion broadcast and FU issue handshake of one RS.
// master = surrounding pipeline (decode, CDB, FU); slave = the station.
interface reservation_station_if #(
  parameter int RSsize     = 4,
  parameter int ROBsizeLog = 4
);
  localparam int cntW = $clog2(RSsize + 1);

  logic                  writeEn_i;
  logic [ROBsizeLog-1:0] ROBTag_i;
  logic [ROBsizeLog-1:0] ROBTag1_i;
  logic [ROBsizeLog-1:0] ROBTag2_i;
  logic [64:0]           ROBval1_i;
  logic [64:0]           ROBval2_i;
  logic [9:0]            commands_i;
  logic                  stall_o;
  logic                  completionValid_i;
  logic [ROBsizeLog-1:0] completionTag_i;
  logic [64:0]           completionVal_i;
  logic                  issueValid_o;
  logic                  issueReady_i;
  logic [ROBsizeLog-1:0] issueTag_o;
  logic [64:0]           issueOp1_o;
  logic [64:0]           issueOp2_o;
  logic [9:0]            issueCommands_o;
  logic [cntW-1:0]       occupancy_o;

  modport master (
    output writeEn_i, ROBTag_i, ROBTag1_i, ROBTag2_i, ROBval1_i, ROBval2_i,
           commands_i, completionValid_i, completionTag_i, completionVal_i,
           issueReady_i,
    input  stall_o, issueValid_o, issueTag_o, issueOp1_o, issueOp2_o,
           issueCommands_o, occupancy_o
  );

  modport slave (
    input  writeEn_i, ROBTag_i, ROBTag1_i, ROBTag2_i, ROBval1_i, ROBval2_i,
           commands_i, completionValid_i, completionTag_i, completionVal_i,
           issueReady_i,
    output stall_o, issueValid_o, issueTag_o, issueOp1_o, issueOp2_o,
           issueCommands_o, occupancy_o
  );
endinterface

// File: rtl/rs_oldest_ready_select.sv
// Priority pick of the lowest-index (oldest) ready slot: one-hot grant,
// binary index and an any-ready flag.
module rs_oldest_ready_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     ready_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  assign grant_o = ready_i & (~ready_i + 1'b1);
  assign any_o   = |ready_i;

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: slot 0 is always the oldest entry.
// Optional macro RS_FLUSH_EN adds a flush_i squash input.
module reservation_station
  import rs_pkg::*;
#(
  parameter int RSsize     = 4,
  parameter int ROBsizeLog = TAG_W
) (
  input  logic clk_i,
  input  logic reset_i,
`ifdef RS_FLUSH_EN
  input  logic flush_i,
`endif
  reservation_station_if.slave rs
);

  localparam int cntW  = $clog2(RSsize + 1);
  localparam int IDX_W = (RSsize > 1) ? $clog2(RSsize) : 1;

  rs_entry_t        entries_q [RSsize];
  rs_entry_t        entries_d [RSsize];
  rs_entry_t        woken_ext [RSsize+1];
  rs_entry_t        new_raw, new_entry, presented;
  logic [cntW-1:0]  count_q, count_d, wslot;
  logic [RSsize-1:0] ready_vec, grant;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready, flush, stall, issue_valid, fire, accept;

`ifdef RS_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Extra always-empty tail slot lets the shift read "slot i+1" uniformly.
  generate
    for (genvar gi = 0; gi < RSsize; gi++) begin : g_slot
      assign ready_vec[gi] = entries_q[gi].valid && (entries_q[gi].tag1 == '0)
                             && (entries_q[gi].tag2 == '0);
      assign woken_ext[gi] = rs_wake(entries_q[gi], rs.completionValid_i,
                                     rs.completionTag_i, rs.completionVal_i);
    end
  endgenerate
  assign woken_ext[RSsize] = '0;

  rs_oldest_ready_select #(.N(RSsize), .IDX_W(IDX_W)) u_select (
    .ready_i (ready_vec),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (any_ready)
  );

  always_comb begin
    new_raw         = '0;
    new_raw.valid   = 1'b1;
    new_raw.destTag = rs.ROBTag_i;
    new_raw.tag1    = rs.ROBTag1_i;
    new_raw.val1    = rs.ROBval1_i;
    new_raw.tag2    = rs.ROBTag2_i;
    new_raw.val2    = rs.ROBval2_i;
    new_raw.cmd     = rs.commands_i;
  end
  assign new_entry = rs_wake(new_raw, rs.completionValid_i, rs.completionTag_i,
                             rs.completionVal_i);

  // Stall looks only at registered occupancy; decode gates its enable with it.
  assign stall       = (count_q == cntW'(RSsize));
  assign issue_valid = any_ready && !flush;
  assign fire        = issue_valid && rs.issueReady_i;
  assign accept      = rs.writeEn_i && !stall && !flush;
  assign wslot       = fire ? (count_q - 1'b1) : count_q;

  always_comb begin
    presented = '0;
    for (int i = 0; i < RSsize; i++) begin
      if (grant[i]) presented = presented | entries_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < RSsize; i++) begin
      if (fire && (i >= int'(sel_idx))) entries_d[i] = woken_ext[i+1];
      else                               entries_d[i] = woken_ext[i];
      if (accept && (cntW'(i) == wslot)) entries_d[i] = new_entry;
      if (flush) entries_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !fire)      count_d = count_q + 1'b1;
    else if (fire && !accept) count_d = count_q - 1'b1;
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int i = 0; i < RSsize; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RSsize; i++) entries_q[i] <= entries_d[i];
    end
  end

  assign rs.stall_o         = stall;
  assign rs.issueValid_o    = issue_valid;
  assign rs.issueTag_o      = presented.destTag;
  assign rs.issueOp1_o      = presented.val1;
  assign rs.issueOp2_o      = presented.val2;
  assign rs.issueCommands_o = presented.cmd;
  assign rs.occupancy_o     = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Randomized plus directed bench for reservation_station against a queue-based
// reference model of the oldest-ready-first station.
module tb_reservation_station;

  localparam int RS = 4;

  typedef struct {
    logic [3:0]  dest, t1, t2;
    logic [64:0] v1, v2;
    logic [9:0]  cmd;
  } m_entry_t;

  logic clk_i = 1'b0;
  logic reset_i;
`ifdef RS_FLUSH_EN
  logic flush_i;
`endif
  int n_checks = 0;
  int n_pass   = 0;
  m_entry_t mq[$];

  always #5 clk_i = ~clk_i;

  reservation_station_if #(.RSsize(RS), .ROBsizeLog(4)) rs_bus ();

  reservation_station #(.RSsize(RS), .ROBsizeLog(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
`ifdef RS_FLUSH_EN
    .flush_i (flush_i),
`endif
    .rs      (rs_bus)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic m_entry_t m_wake(input m_entry_t e, input logic cv,
                                      input logic [3:0] ct, input logic [64:0] cval);
    m_entry_t w = e;
    if (cv && ct != 0 && e.t1 == ct) begin w.t1 = 0; w.v1 = cval; end
    if (cv && ct != 0 && e.t2 == ct) begin w.t2 = 0; w.v2 = cval; end
    return w;
  endfunction

  function automatic logic [64:0] rval();
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return r[64:0];
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic cycle(input logic we, input logic [3:0] dt, input logic [3:0] t1,
                       input logic [3:0] t2, input logic [64:0] v1, input logic [64:0] v2,
                       input logic [9:0] cmd, input logic cv, input logic [3:0] ct,
                       input logic [64:0] cval, input logic rdy, input logic fl);
    int sel;
    logic exp_valid, fire, accept;
    m_entry_t ne;
    @(negedge clk_i);
    rs_bus.writeEn_i = we;        rs_bus.ROBTag_i = dt;
    rs_bus.ROBTag1_i = t1;        rs_bus.ROBTag2_i = t2;
    rs_bus.ROBval1_i = v1;        rs_bus.ROBval2_i = v2;
    rs_bus.commands_i = cmd;      rs_bus.completionValid_i = cv;
    rs_bus.completionTag_i = ct;  rs_bus.completionVal_i = cval;
    rs_bus.issueReady_i = rdy;
`ifdef RS_FLUSH_EN
    flush_i = fl;
`endif
    #1;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].t1 == 0 && mq[i].t2 == 0) sel = i;
    exp_valid = (sel >= 0) && !fl;
    check("stall", rs_bus.stall_o, mq.size() == RS);
    check("occupancy", rs_bus.occupancy_o, mq.size());
    check("issue_valid", rs_bus.issueValid_o, exp_valid);
    check("issue_tag", rs_bus.issueTag_o, sel >= 0 ? mq[sel].dest : 4'd0);
    check("issue_op1", rs_bus.issueOp1_o, sel >= 0 ? mq[sel].v1 : 65'd0);
    check("issue_op2", rs_bus.issueOp2_o, sel >= 0 ? mq[sel].v2 : 65'd0);
    check("issue_cmd", rs_bus.issueCommands_o, sel >= 0 ? mq[sel].cmd : 10'd0);
    fire   = exp_valid && rdy;
    accept = we && (mq.size() < RS) && !fl;
    if (fire) $display("txn issue tag=%0h op1=%0h op2=%0h", mq[sel].dest, mq[sel].v1, mq[sel].v2);
    if (accept) $display("txn alloc tag=%0h t1=%0h t2=%0h", dt, t1, t2);
    foreach (mq[i]) mq[i] = m_wake(mq[i], cv, ct, cval);
    if (fire) mq.delete(sel);
    if (accept) begin
      ne = '{dest: dt, t1: t1, t2: t2, v1: v1, v2: v2, cmd: cmd};
      mq.push_back(m_wake(ne, cv, ct, cval));
    end
    if (fl) mq.delete();
  endtask

  task automatic wr(input logic [3:0] dt, input logic [3:0] t1, input logic [3:0] t2,
                    input logic [64:0] v1, input logic [64:0] v2);
    cycle(1'b1, dt, t1, t2, v1, v2, 10'(dt) ^ 10'h2A5, 1'b0, 4'd0, 65'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 65'd0, 65'd0, 10'd0, 1'b0, 4'd0, 65'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    rs_bus.writeEn_i = 0; rs_bus.completionValid_i = 0; rs_bus.issueReady_i = 0;
`ifdef RS_FLUSH_EN
    flush_i = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("reset_occupancy", rs_bus.occupancy_o, 0);
    check("reset_stall", rs_bus.stall_o, 0);
    check("reset_issue_valid", rs_bus.issueValid_o, 0);
    check("reset_issue_tag", rs_bus.issueTag_o, 0);
    check("reset_issue_op1", rs_bus.issueOp1_o, 0);
    mq.delete();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    rs_bus.writeEn_i = 0; rs_bus.ROBTag_i = 0; rs_bus.ROBTag1_i = 0; rs_bus.ROBTag2_i = 0;
    rs_bus.ROBval1_i = 0; rs_bus.ROBval2_i = 0; rs_bus.commands_i = 0;
    rs_bus.completionValid_i = 0; rs_bus.completionTag_i = 0; rs_bus.completionVal_i = 0;
    rs_bus.issueReady_i = 0;
`ifdef RS_FLUSH_EN
    flush_i = 1'b0;
`endif

    // Fill, drop a write while full, then full + fire + write in one cycle.
    do_reset();
    for (int i = 1; i <= 4; i++) wr(4'(i), 0, 0, 65'(i * 16), 65'(i * 17));
    idle(1'b0);
    check("full_occupancy", rs_bus.occupancy_o, 4);
    check("full_stall", rs_bus.stall_o, 1);
    wr(4'd9, 0, 0, 65'h99, 65'h99);
    idle(1'b0);
    check("drop_occupancy", rs_bus.occupancy_o, 4);
    check("drop_head_tag", rs_bus.issueTag_o, 1);
    cycle(1'b1, 4'd10, 0, 0, 65'h10, 65'h10, 10'h3, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(1'b0);
    check("fire_full_occupancy", rs_bus.occupancy_o, 3);
    check("fire_full_stall", rs_bus.stall_o, 0);
    check("fire_full_head", rs_bus.issueTag_o, 2);

    // Younger ready entry issues first; older one wakes and follows.
    do_reset();
    wr(4'd5, 4'd3, 4'd0, 65'd0, 65'h77);
    wr(4'd6, 4'd0, 4'd0, 65'h1, 65'h2);
    idle(1'b0);
    check("young_first_valid", rs_bus.issueValid_o, 1);
    check("young_first_tag", rs_bus.issueTag_o, 6);
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 4'd3, 65'h1234, 1'b1, 1'b0);
    idle(1'b0);
    check("woken_tag", rs_bus.issueTag_o, 5);
    check("woken_op1", rs_bus.issueOp1_o, 65'h1234);

    // Fire middle slot; the shifted entry keeps fields and catches a wakeup.
    do_reset();
    wr(4'd1, 4'd2, 4'd0, 65'h11, 65'h12);
    wr(4'd2, 4'd0, 4'd0, 65'h21, 65'h22);
    wr(4'd3, 4'd0, 4'd5, 65'hAA, 65'h0);
    idle(1'b0);
    check("mid_sel_tag", rs_bus.issueTag_o, 2);
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 4'd5, 65'h55, 1'b1, 1'b0);
    idle(1'b0);
    check("shift_tag", rs_bus.issueTag_o, 3);
    check("shift_op1", rs_bus.issueOp1_o, 65'hAA);
    check("shift_op2", rs_bus.issueOp2_o, 65'h55);
    check("shift_occupancy", rs_bus.occupancy_o, 2);

    // Allocation woken by the broadcast in its own write cycle.
    do_reset();
    cycle(1'b1, 4'd4, 4'd0, 4'd7, 65'h3, 65'h0, 10'h1, 1'b1, 4'd7, 65'hFF, 1'b0, 1'b0);
    idle(1'b0);
    check("alloc_wake_valid", rs_bus.issueValid_o, 1);
    check("alloc_wake_op2", rs_bus.issueOp2_o, 65'hFF);
    check("alloc_wake_tag", rs_bus.issueTag_o, 4);

`ifdef RS_FLUSH_EN
    do_reset();
    for (int i = 1; i <= 3; i++) wr(4'(i), 0, 0, 65'(i), 65'(i));
    cycle(1'b1, 4'd8, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
    check("flush_issue_valid", rs_bus.issueValid_o, 0);
    idle(1'b0);
    check("flush_occupancy", rs_bus.occupancy_o, 0);
`endif

    // Random traffic; small tag range so wakeups and tag-0 broadcasts happen often.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic fl = 1'b0;
`ifdef RS_FLUSH_EN
      fl = ($urandom_range(0, 31) == 0);
`endif
      cycle($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
            4'($urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 3)),
            4'($urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 3)),
            rval(), rval(), 10'($urandom), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 3)), rval(), $urandom_range(0, 2) != 0, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Single reservation station instance, one per functional-unit class (whichMath 0..3).
- Consumes the decode stage's RS write port (tags, operand values, commands) and reports back through stall_o.
- Snoops the completion broadcast to wake up waiting operands.
- Issues the oldest ready entry to its functional unit over a valid/ready handshake. Storage is a collapsing queue, so entry 0 is always the oldest.

Parameters:
RSsize, 4, number of entries
ROBsizeLog, 4, ROB tag width; tag value 0 means "operand value present"
cntW, $clog2(RSsize+1), occupancy counter width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
writeEn_i  in  1  allocate request from decode (RSWriteEn_o[n])
ROBTag_i  in  ROBsizeLog  destination ROB tag
ROBTag1_i  in  ROBsizeLog  operand-1 source tag (0 = ready)
ROBTag2_i  in  ROBsizeLog  operand-2 source tag (0 = ready)
ROBval1_i  in  65  operand-1 value; bit 64 carried unchanged
ROBval2_i  in  65  operand-2 value; bit 64 carried unchanged
commands_i  in  10  control bundle {read_enable, saveCond, leftShift, needToForward, regWrite, ALUOp[2:0], memToReg, memWrite}
stall_o  out  1  RS full (to decode RSstall_i[n])
completionValid_i  in  1  completion broadcast valid (robWriteEn)
completionTag_i  in  ROBsizeLog  completing ROB tag
completionVal_i  in  65  completing value
issueValid_o  out  1  a ready entry is presented
issueReady_i  in  1  functional unit accepts
issueTag_o  in/out: out  ROBsizeLog  destination tag of presented entry
issueOp1_o  out  65  operand 1
issueOp2_o  out  65  operand 2
issueCommands_o  out  10  command bundle
occupancy_o  out  cntW  valid entry count

Behaviour:
- Entry state: valid, destTag, tag1, val1, tag2, val2, cmd. Valid entries are always contiguous in slots 0..count-1.
- Reset: all valid bits 0, count 0. Outputs: stall_o=0, issueValid_o=0, occupancy_o=0; data outputs 0.
- stall_o = (count == RSsize). It depends on registered state only and never on writeEn_i or issue, because decode ANDs it with its write enable combinationally.
- Allocate: accepted when writeEn_i & ~stall_o; captured at the next edge.
  - A write while stall_o=1 is dropped silently, even if an issue fires in the same cycle.
- Wakeup, every cycle, per valid entry and per operand:
  - If tagN != 0, completionValid_i is high and tagN == completionTag_i, then at the edge valN <= completionVal_i and tagN <= 0.
  - The incoming allocation's operands get the same check in the same cycle.
- Ready = valid & tag1==0 & tag2==0, evaluated on registered state. A woken operand is issuable the cycle after wakeup; there is no same-cycle wakeup-to-issue.
- Select: lowest-index ready entry.
  - issueValid_o is combinational = any ready.
  - issue* outputs come from the selected entry; they are 0 when none is ready.
- Fire = issueValid_o & issueReady_i. On fire of slot k, slots k+1..count-1 shift to k..count-2 at the edge, carrying any same-cycle wakeup.
- Write slot: count (no fire) or count-1 (fire). Count update: +1 on accept, -1 on fire, unchanged when both or neither.
- issueReady_i low: the presented entry holds and outputs stay stable. A later-ready older entry may preempt a younger presented one, because select is not sticky.
- Tag 0 on the completion bus never wakes anything.

Optional Feature:
- Macro: RS_FLUSH_EN.
- Defined:
  - Adds input port flush_i (1 bit, branch-mispredict squash).
  - When flush_i=1: issueValid_o forced 0, writes ignored, and at the edge all valid bits clear and count goes to 0.
  - Flush has priority over allocate, issue and wakeup.
- Undefined: no port; entries leave only by issue or reset.

Decomposition:
- Package rs_pkg holds:
  - CMD_W=10, VAL_W=65.
  - Typedef rs_entry_t (struct: valid, destTag, tag1, val1, tag2, val2, cmd).
  - Command-bit index localparams (MEMWRITE=0 ... READEN=9), shared with decodeStage.
- One sub-module, rs_oldest_ready_select: RSsize-wide ready vector in, one-hot grant plus index and anyReady out.

Test Plan:
- Reset, then write 4 entries with all tags 0 and issueReady_i=0 -> occupancy_o=4 and stall_o=1. A 5th write is dropped: occupancy stays 4 and entry 0 data is still presented.
- Write A (tag1=3, dest=5) then B (tags 0, dest=6) -> issueValid_o=1 with issueTag_o=6. Then completion tag 3 val 0x1234 -> next cycle, after B fires, A issues with issueOp1_o=0x1234.
- Full RS with issueReady_i=1 for entry 0 and writeEn_i=1 in the same cycle -> write dropped; occupancy goes 4→3; stall_o=0 on the next cycle.
- Entries at slots 0..2 with only slot 1 ready -> fire slot 1; slot 2 moves to slot 1 with its fields intact; a completion in the same cycle is applied to the shifted entry.
- Allocate with tag2=7 while the completion bus broadcasts tag 7 val 0xFF -> entry stored with tag2=0 and val2=0xFF, issuable the next cycle.
- RS_FLUSH_EN: 3 entries valid, flush_i=1 together with writeEn_i=1 -> issueValid_o=0 that cycle; occupancy_o=0 next cycle.
